// File: rtl/bit_serializer_if.sv
// Parallel-word handshake between an upstream producer and the bit serializer.
// The producer drives the master side; the serializer uses the slave side.
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence-detector path.
// A one-word holding register ahead of the shifter lets words stream back-to-back with no idle bit.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  in_if,
    input  logic             ser_en,
    output logic             data_out,
    output logic             bit_valid,
    output logic             word_start,
    output logic             word_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             load;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Accept and load can never coincide: accept needs an empty holding register, load a full one.
    assign in_if.in_ready = !hold_full;
    assign accept         = in_if.in_valid && !hold_full;
    assign load           = ser_en && (cnt == '0) && hold_full;
    assign busy           = hold_full || (cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= in_if.in_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // The first bit of a freshly loaded word leaves on the load edge itself, so the
    // shifter keeps only the remaining WIDTH-1 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            data_out   <= IDLE_BIT;
            bit_valid  <= 1'b0;
            word_start <= 1'b0;
            word_last  <= 1'b0;
        end else if (ser_en) begin
            if (cnt != '0) begin
                data_out   <= first_bit(shift_reg);
                shift_reg  <= advance(shift_reg);
                cnt        <= cnt - CW'(1);
                bit_valid  <= 1'b1;
                word_start <= 1'b0;
                word_last  <= (cnt == CW'(1));
            end else if (hold_full) begin
                data_out   <= first_bit(hold_reg);
                shift_reg  <= advance(hold_reg);
                cnt        <= CW'(WIDTH - 1);
                bit_valid  <= 1'b1;
                word_start <= 1'b1;
                word_last  <= 1'b0;
            end else begin
                data_out   <= IDLE_BIT;
                bit_valid  <= 1'b0;
                word_start <= 1'b0;
                word_last  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the serial sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake, then emits them one bit per bit-enable strobe on a single serial line. The serial line feeds the detector's data_in directly. A one-word holding register sits ahead of the shift register, so back-to-back words stream with no idle bit between them.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first
IDLE_BIT, 1'b0, value driven on data_out when no word bit is being emitted

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  parallel word
ser_en  input  1  bit-rate strobe; one serial bit advances per clk edge with ser_en=1
data_out  output  1  serial bit (registered)
bit_valid  output  1  data_out currently carries a word bit (registered)
word_start  output  1  data_out is the first bit of a word (registered)
word_last  output  1  data_out is the last bit of a word (registered)
busy  output  1  holding register full or shifter has bits remaining

Behaviour:
- Reset: clk edge with reset=1 sets data_out=IDLE_BIT, bit_valid=0, word_start=0, word_last=0, hold_full=0, bit count=0. Reset overrides every other event. Any in-flight or held word is discarded. in_ready=1 from the first cycle after reset.
- Internal state:
  - hold_reg[WIDTH] plus hold_full.
  - shift_reg[WIDTH] plus cnt, the number of bits still to emit (0..WIDTH-1, width clog2(WIDTH)+1).
- Handshake:
  - in_ready = !hold_full, combinational from register state only, with no dependence on in_valid.
  - Accept occurs on an edge with in_valid & in_ready: hold_reg <= in_data, hold_full <= 1.
  - in_data is ignored when not accepted.
  - The upstream side must hold in_valid/in_data until accepted.
- Serial advance happens only on clk edges with ser_en=1, in priority order:
  1. cnt>0: shift the next bit to data_out (MSB_FIRST selects the direction); cnt <= cnt-1; bit_valid=1; word_start=0; word_last=(cnt==1).
  2. cnt==0 and hold_full: load shift_reg from hold_reg. The first bit goes to data_out on this same edge. Set cnt <= WIDTH-1, bit_valid=1, word_start=1, word_last=0, hold_full <= 0.
  3. Otherwise: data_out=IDLE_BIT, bit_valid=0, word_start=0, word_last=0.
- ser_en=0: all serial outputs and cnt hold their values. Handshake acceptance still proceeds.
- No simultaneous accept-and-load conflict:
  - Accept requires hold_full=0.
  - Load requires hold_full=1.
  - A word accepted on edge N is first loadable on the next ser_en edge after N.
- Latency: with ser_en tied high, a word accepted on edge N shows its first bit on data_out after edge N+1 and its last bit after edge N+WIDTH.
- Throughput:
  - A next word accepted while the shifter is active is loaded on the ser_en edge immediately after its predecessor's last bit.
  - bit_valid stays continuously 1 across the word boundary, with no gap.
- busy = hold_full | (cnt != 0), combinational.

Test Plan:
- WIDTH=8, MSB_FIRST=1, ser_en=1. Reset 2 cycles, accept 0xA5 -> data_out sequence 1,0,1,0,0,1,0,1 on the 8 cycles after the first ser_en edge following the accept. word_start only on the first bit, word_last only on the 8th. Then data_out=0 and bit_valid=0.
- Words 0xA5 and 0x3C presented back-to-back with in_valid held high -> 16 consecutive bit_valid=1 cycles: 10100101 00111100. in_ready=0 from accept of 0x3C until 0x3C is loaded. word_start is high on bits 1 and 9.
- ser_en pulsed every 3rd cycle, word 0xF0 -> each bit held exactly 3 cycles. Bits 11110000. No bit skipped or repeated.
- MSB_FIRST=0, word 0x01 -> data_out 1,0,0,0,0,0,0,0.
- Reset asserted after the 4th bit of 0xFF with a second word 0x0F held -> the next cycle has data_out=IDLE_BIT, bit_valid=0, busy=0, in_ready=1. No remaining bits of either word are ever emitted.
- in_valid high with in_ready=0 and in_data changing -> the changed data is not captured. After hold frees, the value present at the accepting edge is serialized.
